// File: rtl/btn_debounce_pulse_pkg.sv
// Shared definitions for the pushbutton conditioning block.
//   state_t        : per-channel debounce FSM state encoding
//   is_level_high(): debounced level implied by a given FSM state
package btn_debounce_pulse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_HIGH    = 2'd2,
        ST_WAIT_LO = 2'd3
    } state_t;

    // The accepted level stays high while a release is still being qualified.
    function automatic logic is_level_high(state_t st);
        return (st == ST_HIGH) || (st == ST_WAIT_LO);
    endfunction

endpackage

// File: rtl/btn_debounce_pulse_debounce_chan.sv
// One pushbutton channel: 2-flop synchroniser, counter-based debounce FSM and
// a one-cycle strobe on every accepted press.
// Ports:
//   clk       in  1  system clock
//   rst_n     in  1  asynchronous active-low reset
//   btn_raw   in  1  raw asynchronous button, 1 = pressed
//   btn_level out 1  debounced level (registered)
//   btn_pulse out 1  one-cycle strobe on debounced 0->1 (registered)
import btn_debounce_pulse_pkg::*;

module debounce_chan #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_p0;
    logic             sync_p1;
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             level_n;
    logic             pulse_n;

    // Stage p0/p1: synchroniser; sync_p1 is the only view of the button the FSM gets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0   <= 1'b0;
            sync_p1   <= 1'b0;
            state     <= ST_IDLE;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_pulse <= 1'b0;
        end else begin
            sync_p0   <= btn_raw;
            sync_p1   <= sync_p0;
            state     <= state_n;
            cnt       <= cnt_n;
            btn_level <= level_n;
            btn_pulse <= pulse_n;
        end
    end

    // FSM stage: cnt counts consecutive samples that disagree with the accepted level.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pulse_n = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sync_p1) begin
                    state_n = ST_WAIT_HI;
                    cnt_n   = CNT_ONE;
                end
            end
            ST_WAIT_HI: begin
                if (!sync_p1) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = ST_HIGH;
                    pulse_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!sync_p1) begin
                    state_n = ST_WAIT_LO;
                    cnt_n   = CNT_ONE;
                end
            end
            ST_WAIT_LO: begin
                // Returning to HIGH here is a release bounce, never a new press.
                if (sync_p1) begin
                    state_n = ST_HIGH;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
        level_n = is_level_high(state_n);
    end

endmodule

// File: rtl/btn_debounce_pulse.sv
// Pushbutton conditioning for the comparator operand-load buttons: one
// independent debounce channel per button.
// Ports:
//   clk       in  1      system clock
//   rst_n     in  1      asynchronous active-low reset
//   btn_raw   in  N_BTN  raw asynchronous buttons, 1 = pressed
//   btn_level out N_BTN  debounced levels
//   btn_pulse out N_BTN  one-cycle strobe per accepted press
module btn_debounce_pulse #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn_raw  (btn_raw[i]),
            .btn_level(btn_level[i]),
            .btn_pulse(btn_pulse[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
module tb_btn_debounce_pulse;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] btn_raw = 2'b00;
    logic [1:0] btn_level;
    logic [1:0] btn_pulse;

    int checks = 0;
    int errors = 0;
    int pcount [2];

    // Reference: raw delayed two samples; a level is accepted after DC
    // consecutive samples that disagree with the current accepted level.
    logic [1:0] m_d1, m_d2, m_lvl, m_pul;
    int         m_run [2];

    btn_debounce_pulse #(.N_BTN(2), .DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_d1 = '0; m_d2 = '0; m_lvl = '0; m_pul = '0;
        m_run[0] = 0; m_run[1] = 0;
    endtask

    task automatic model_edge(input logic [1:0] raw);
        for (int c = 0; c < 2; c++) begin
            logic s;
            s = m_d2[c];
            m_pul[c] = 1'b0;
            if (s != m_lvl[c]) begin
                m_run[c]++;
                if (m_run[c] == DC) begin
                    m_lvl[c] = s;
                    m_pul[c] = s;
                    m_run[c] = 0;
                end
            end else begin
                m_run[c] = 0;
            end
        end
        m_d2 = m_d1;
        m_d1 = raw;
    endtask

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_clear();
        else model_edge(btn_raw);
        #1;
        chk("model_level", btn_level, m_lvl);
        chk("model_pulse", btn_pulse, m_pul);
        for (int c = 0; c < 2; c++) if (btn_pulse[c] === 1'b1) pcount[c]++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        model_clear();
        pcount[0] = 0; pcount[1] = 0;

        // 1: reset, then idle inputs
        #2;
        chk("reset_level", btn_level, 2'b00);
        chk("reset_pulse", btn_pulse, 2'b00);
        ticks(2);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_level", btn_level, 2'b00);
            chk("idle_pulse", btn_pulse, 2'b00);
        end

        // 2: press channel 0 and hold
        btn_raw = 2'b01;
        for (int i = 0; i <= 5; i++) begin
            tick();
            chk("press0_pulse", btn_pulse, (i == 5) ? 2'b01 : 2'b00);
            chk("press0_level", btn_level, (i == 5) ? 2'b01 : 2'b00);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold0_pulse", btn_pulse, 2'b00);
            chk("hold0_level", btn_level, 2'b01);
        end

        // 3: channel 1 bounces, then settles high, then a short release glitch
        pcount[1] = 0;
        for (int k = 0; k < 4; k++) begin
            btn_raw[1] = (k % 2 == 0);
            ticks(2);
        end
        chk("bounce1_level", btn_level, 2'b01);
        btn_raw[1] = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            tick();
            chk("rise1_pulse", btn_pulse, (i == 5) ? 2'b10 : 2'b00);
        end
        ticks(4);
        btn_raw[1] = 1'b0;
        tick();
        btn_raw[1] = 1'b1;
        ticks(10);
        chk("glitch1_level", btn_level, 2'b11);
        checks++;
        assert (pcount[1] == 1) else begin
            errors++;
            $error("FAIL pulses_ch1: observed %0d expected 1", pcount[1]);
        end

        // 4: simultaneous press on both channels
        btn_raw = 2'b00;
        ticks(10);
        chk("both_released", btn_level, 2'b00);
        btn_raw = 2'b11;
        for (int i = 0; i <= 5; i++) begin
            tick();
            chk("both_pulse", btn_pulse, (i == 5) ? 2'b11 : 2'b00);
        end

        // 5: async reset with channel 0 mid-qualification, channel 1 high
        btn_raw = 2'b10;
        ticks(10);
        chk("pre_rst_level", btn_level, 2'b10);
        btn_raw = 2'b11;
        ticks(4);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        chk("async_rst_level", btn_level, 2'b00);
        chk("async_rst_pulse", btn_pulse, 2'b00);
        ticks(2);
        #2 rst_n = 1'b1;
        for (int j = 0; j <= 5; j++) begin
            tick();
            chk("post_rst_pulse", btn_pulse, (j == 5) ? 2'b11 : 2'b00);
        end

        // 6: press / release / press on channel 0
        btn_raw = 2'b00;
        ticks(10);
        pcount[0] = 0;
        btn_raw = 2'b01;
        ticks(10);
        btn_raw = 2'b00;
        for (int i = 0; i <= 5; i++) begin
            tick();
            chk("release0_level", btn_level, (i == 5) ? 2'b00 : 2'b01);
        end
        ticks(4);
        btn_raw = 2'b01;
        ticks(10);
        checks++;
        assert (pcount[0] == 2) else begin
            errors++;
            $error("FAIL pulses_ch0: observed %0d expected 2", pcount[0]);
        end

        // Random bouncing against the reference model
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < 2; c++)
                if ($urandom_range(0, 4) == 0) btn_raw[c] = ~btn_raw[c];
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
